// File: rtl/mul32_pkg.sv
// mul32_pkg: shared state encoding and iteration constants for the sequential multiplier
package mul32_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam int MUL_ITER = 32;
   localparam int CNT_W    = 5;
endpackage

// File: rtl/cla32_ov.sv
// cla32_ov: 32-bit carry-lookahead adder, 4-bit groups with group-level lookahead,
// exposing carry-out and the carry into bit 31 for signed overflow detection
module cla32_ov (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] sum,
   output logic        co,
   output logic        co_prev
);
   logic [31:0] w_g, w_p, w_cin;
   logic [7:0]  w_gg, w_pg;
   logic [8:0]  w_cg;
   assign w_g = a & b;
   assign w_p = a ^ b;
   for (genvar j = 0; j < 8; j++) begin : g_grp
      logic [3:0] w_gl, w_pl;
      assign w_gl    = w_g[4*j +: 4];
      assign w_pl    = w_p[4*j +: 4];
      assign w_gg[j] = w_gl[3] | w_pl[3] & w_gl[2] | (&w_pl[3:2]) & w_gl[1] | (&w_pl[3:1]) & w_gl[0];
      assign w_pg[j] = &w_pl;
      assign w_cin[4*j +: 4] = {
         w_gl[2] | w_pl[2] & w_gl[1] | (&w_pl[2:1]) & w_gl[0] | (&w_pl[2:0]) & w_cg[j],
         w_gl[1] | w_pl[1] & w_gl[0] | (&w_pl[1:0]) & w_cg[j],
         w_gl[0] | w_pl[0] & w_cg[j],
         w_cg[j]};
   end
   // group carries resolved through a local variable so the vector never feeds itself
   always_comb begin
      logic w_c;
      w_c = ci;
      w_cg = '0;
      for (int i = 0; i < 8; i++) begin
         w_cg[i] = w_c;
         w_c = w_gg[i] | w_pg[i] & w_c;
      end
      w_cg[8] = w_c;
   end
   assign sum     = w_p ^ w_cin;
   assign co      = w_cg[8];
   assign co_prev = w_cin[31];
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: 32x32 unsigned shift-add multiplier sharing one cla32_ov over 32 cycles,
// 33-cycle latency from accepted start to a one-cycle done strobe
module mul32_seq
   import mul32_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITER - 1);
   state_t            r_state, w_next;
   logic [31:0]       r_mcand, r_hi, r_lo, w_sum;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_co, w_load, w_last;
   logic [63:0]       w_hl;
   cla32_ov u_add (
      .a       (r_hi),
      .b       (r_mcand),
      .ci      (1'b0),
      .sum     (w_sum),
      .co      (w_co),
      .co_prev ()
   );
   assign w_last = r_cnt == LAST;
   assign w_load = start && r_state != CALC;
   assign w_hl   = r_lo[0] ? {w_co, w_sum, r_lo[31:1]} : {1'b0, r_hi, r_lo[31:1]};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   always_comb begin
      w_next = r_state == CALC ? (w_last ? DONE : CALC) : (start ? CALC : IDLE);
      busy   = r_state == CALC;
      done   = r_state == DONE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         result  <= '0;
      end else if (w_load) begin
         r_mcand <= a;
         r_hi    <= '0;
         r_lo    <= b;
         r_cnt   <= '0;
      end else if (r_state == CALC) begin
         {r_hi, r_lo} <= w_hl;
         r_cnt        <= r_cnt + 1'b1;
         if (w_last) result <= w_hl;
      end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: random and directed checks of mul32_seq against plain 64-bit multiplication
module tb_mul32_seq;
   logic        clk = 0, reset_n = 0, start = 0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [63:0] result;
   int          n_chk = 0, n_err = 0;

   mul32_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // waits for done after the accepting edge; returns edges elapsed and busy-cycle count
   task automatic wait_done(output int n, output int nb);
      n = 0;
      nb = 0;
      while (!done && n < 40) begin
         if (busy) nb++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
      int n, nb;
      @(negedge clk);
      a = x;
      b = y;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      wait_done(n, nb);
      chk({tag, "_lat"}, 64'(n), 64'd32);
      chk({tag, "_busy"}, 64'(nb), 64'd32);
      chk({tag, "_res"}, result, 64'(x) * 64'(y));
      chk({tag, "_excl"}, 64'(busy & done), 64'd0);
   endtask

   initial begin
      int n, nb, ndone;
      logic [63:0] held;
      logic        ok;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res", result, 64'd0);
      @(negedge clk);
      reset_n = 1;
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'd0);

      run_op("basic", 32'd3, 32'd5);
      @(posedge clk);
      #1;
      chk("strobe_drop", 64'(done), 64'd0);
      chk("res_hold", result, 64'hF);
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("max_const", result, 64'hFFFF_FFFE_0000_0001);
      run_op("zero", 32'd0, 32'h1234_5678);
      run_op("ident", 32'h1234_5678, 32'd1);

      // a start pulse mid-iteration must be ignored
      @(negedge clk);
      a = 7;
      b = 9;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      ndone = 0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 10) begin
            a = 2;
            b = 2;
            start = 1;
         end
         @(posedge clk);
         #1 start = 0;
         if (done) begin
            ndone++;
            if (n == 0) n = i;
            chk("ign_res", result, 64'd63);
         end
      end
      chk("ign_ndone", 64'(ndone), 64'd1);
      chk("ign_lat", 64'(n), 64'd32);

      // back-to-back: start held into DONE, first product held until the second completes
      run_op("b2b1", 32'd11, 32'd13);
      held = result;
      a = 32'h10000;
      b = 32'h10000;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_done", 64'(done), 64'd0);
      ok = 1;
      n = 1;
      while (!done && n < 40) begin
         if (result !== held) ok = 0;
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b_held", 64'(ok), 64'd1);
      chk("b2b_gap", 64'(n), 64'd33);
      chk("b2b_res", result, 64'h0000_0001_0000_0000);

      // asynchronous reset mid-operation
      @(negedge clk);
      a = 32'hDEAD_BEEF;
      b = 32'h0BAD_F00D;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (14) @(posedge clk);
      #2 reset_n = 0;
      #1;
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_done", 64'(done), 64'd0);
      chk("ar_res", result, 64'd0);
      @(negedge clk);
      reset_n = 1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      chk("ar_quiet", 64'(ndone), 64'd0);
      run_op("ar_after", 32'd1000, 32'd1000);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = $urandom;
         if (i % 4 == 1) x = x | 32'hFFFF_0000;
         if (i % 4 == 2) y = y & 32'h8000_00FF;
         run_op("rnd", x, y);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
